// File: rtl/spectrum_averager_if.sv
// AXI-stream style bus used on both sides of the spectrum averager.
// The master modport drives data/valid/last and receives ready; the slave modport is the mirror image.
interface spectrum_averager_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tlast;
    logic              tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/spectrum_averager.sv
// spectrum_averager: accumulates 2^AVG_POW2 consecutive BINS-bin power frames per bin
// and emits one averaged frame per group on an AXI-stream master, framed with tlast.
// Optional macro SPECTRUM_AVERAGER_ROUND_EN: round-half-up (with saturation) instead of
// truncation when dividing the accumulated sum by 2^AVG_POW2.
module spectrum_averager #(
    parameter int BINS     = 256,
    parameter int DATA_W   = 32,
    parameter int AVG_POW2 = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    spectrum_averager_if.slave  s_axis,
    spectrum_averager_if.master m_axis,
    output logic                frame_err
);

    localparam int ACC_W = DATA_W + AVG_POW2;
    localparam int BIN_W = $clog2(BINS);
    localparam int FRM_W = (AVG_POW2 > 0) ? AVG_POW2 : 1;

    localparam logic [BIN_W-1:0] LAST_BIN   = BIN_W'(BINS - 1);
    localparam logic [FRM_W-1:0] LAST_FRAME = FRM_W'((1 << AVG_POW2) - 1);

    localparam logic [1:0] ST_FIRST = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_FINAL = 2'd2;

    logic [BIN_W-1:0]  bin_cnt_q, bin_cnt_d;
    logic [FRM_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [DATA_W-1:0] m_tdata_q, m_tdata_d;
    logic              m_tvalid_q, m_tvalid_d;
    logic              m_tlast_q, m_tlast_d;
    logic              frame_err_q, frame_err_d;

    logic [1:0]        state;
    logic              s_ready;
    logic              accept;
    logic              last_bin;
    logic              framing_err;
    logic              ram_we;
    logic [ACC_W-1:0]  ram_wdata;
    logic [ACC_W-1:0]  ram_rdata;
    logic [ACC_W-1:0]  sum;
    logic [DATA_W-1:0] avg;

    // Per-bin accumulator; never cleared because the first frame of a group overwrites it
    logic [ACC_W-1:0]  acc_mem [BINS];

    assign ram_rdata = acc_mem[bin_cnt_q];

    // Decode the averaging phase from the frame counter (final wins when only one frame is averaged)
    always_comb begin
        state = ST_ACCUM;
        if (frame_cnt_q == LAST_FRAME) begin
            state = ST_FINAL;
        end else if (frame_cnt_q == '0) begin
            state = ST_FIRST;
        end
    end

`ifdef SPECTRUM_AVERAGER_ROUND_EN
    localparam logic [ACC_W:0] ROUND_INC = (ACC_W + 1)'((1 << AVG_POW2) >> 1);

    logic [ACC_W:0] rounded;
    logic [ACC_W:0] shifted;

    // Final sum and its rounded, saturated average
    always_comb begin
        sum     = (AVG_POW2 == 0) ? ACC_W'(s_axis.tdata) : ram_rdata + ACC_W'(s_axis.tdata);
        rounded = {1'b0, sum} + ROUND_INC;
        shifted = rounded >> AVG_POW2;
        avg     = (|shifted[ACC_W:DATA_W]) ? '1 : shifted[DATA_W-1:0];
    end
`else
    // Final sum and its truncated average
    always_comb begin
        sum = (AVG_POW2 == 0) ? ACC_W'(s_axis.tdata) : ram_rdata + ACC_W'(s_axis.tdata);
        avg = DATA_W'(sum >> AVG_POW2);
    end
`endif

    // Handshake, framing check, counter advance, accumulator write and output register load
    always_comb begin
        s_ready     = (state == ST_FINAL) ? (~m_tvalid_q | m_axis.tready) : 1'b1;
        accept      = s_axis.tvalid & s_ready;
        last_bin    = (bin_cnt_q == LAST_BIN);
        framing_err = accept & (s_axis.tlast ^ last_bin);

        bin_cnt_d   = bin_cnt_q;
        frame_cnt_d = frame_cnt_q;
        if (accept) begin
            if (framing_err) begin
                bin_cnt_d   = '0;
                frame_cnt_d = '0;
            end else if (last_bin) begin
                bin_cnt_d   = '0;
                frame_cnt_d = (frame_cnt_q == LAST_FRAME) ? '0 : frame_cnt_q + 1'b1;
            end else begin
                bin_cnt_d = bin_cnt_q + 1'b1;
            end
        end

        ram_we    = accept & (state != ST_FINAL);
        ram_wdata = (state == ST_FIRST) ? ACC_W'(s_axis.tdata) : ram_rdata + ACC_W'(s_axis.tdata);

        m_tvalid_d = m_tvalid_q;
        m_tdata_d  = m_tdata_q;
        m_tlast_d  = m_tlast_q;
        if (m_tvalid_q & m_axis.tready) begin
            m_tvalid_d = 1'b0;
        end
        if (accept & (state == ST_FINAL)) begin
            m_tvalid_d = 1'b1;
            m_tdata_d  = avg;
            m_tlast_d  = last_bin | s_axis.tlast;
        end

        frame_err_d = framing_err;
    end

    // Accumulator write port
    always_ff @(posedge clk) begin
        if (ram_we) begin
            acc_mem[bin_cnt_q] <= ram_wdata;
        end
    end

    // Counters, output register and error pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_cnt_q   <= '0;
            frame_cnt_q <= '0;
            m_tdata_q   <= '0;
            m_tvalid_q  <= 1'b0;
            m_tlast_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            bin_cnt_q   <= bin_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            m_tdata_q   <= m_tdata_d;
            m_tvalid_q  <= m_tvalid_d;
            m_tlast_q   <= m_tlast_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign s_axis.tready = s_ready;
    assign m_axis.tdata  = m_tdata_q;
    assign m_axis.tvalid = m_tvalid_q;
    assign m_axis.tlast  = m_tlast_q;
    assign frame_err     = frame_err_q;

endmodule

// File: tb/tb_spectrum_averager.sv
// Testbench for spectrum_averager: an 8-bin, 4-frame averaging instance plus a
// 4-bin pass-through instance (AVG_POW2=0). Expected output comes from a per-bin
// sum/divide model; SPECTRUM_AVERAGER_ROUND_EN selects the rounding model.
module tb_spectrum_averager;

    localparam int BINS = 8;
    localparam int NF   = 4;
    localparam int DW   = 32;

    logic clk = 1'b0;
    logic rst_n;
    logic frame_err;
    logic frame_err0;

    always #5 clk = ~clk;

    spectrum_averager_if #(.DATA_W(DW)) s_if ();
    spectrum_averager_if #(.DATA_W(DW)) m_if ();
    spectrum_averager_if #(.DATA_W(DW)) s0_if ();
    spectrum_averager_if #(.DATA_W(DW)) m0_if ();

    spectrum_averager #(.BINS(BINS), .DATA_W(DW), .AVG_POW2(2)) dut (
        .clk(clk), .rst_n(rst_n), .s_axis(s_if), .m_axis(m_if), .frame_err(frame_err)
    );

    spectrum_averager #(.BINS(4), .DATA_W(DW), .AVG_POW2(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .s_axis(s0_if), .m_axis(m0_if), .frame_err(frame_err0)
    );

    // Output ready: 0 = held low, 1 = held high, 2 = random per cycle
    logic [1:0] rdy_mode = 2'd1;
    logic       rnd_bit = 1'b1;
    assign m_if.tready  = (rdy_mode == 2'd2) ? rnd_bit : rdy_mode[0];
    assign m0_if.tready = 1'b1;

    int n_vec  = 0;
    int n_miss = 0;
    int err_cnt = 0;

    logic [31:0] frm [NF][BINS];
    logic [31:0] exp_d[$];
    bit          exp_l[$];
    logic [31:0] obs_d[$];
    bit          obs_l[$];

    initial forever begin
        @(posedge clk);
        #1 rnd_bit = 1'($urandom_range(0, 1));
    end

    // Record every completed output handshake and every error pulse
    initial forever begin
        @(negedge clk);
        if (rst_n === 1'b1) begin
            if (m_if.tvalid === 1'b1 && m_if.tready === 1'b1) begin
                obs_d.push_back(m_if.tdata);
                obs_l.push_back(m_if.tlast);
            end
            if (frame_err === 1'b1) err_cnt++;
        end
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [31:0] model_avg(input longint unsigned sum);
        longint unsigned r;
`ifdef SPECTRUM_AVERAGER_ROUND_EN
        r = (sum + NF / 2) / NF;
`else
        r = sum / NF;
`endif
        if (r > 64'hFFFF_FFFF) r = 64'hFFFF_FFFF;
        return r[31:0];
    endfunction

    task automatic push_expected(input int nbins);
        longint unsigned sum;
        for (int k = 0; k < nbins; k++) begin
            sum = 0;
            for (int f = 0; f < NF; f++) sum += longint'(frm[f][k]);
            exp_d.push_back(model_avg(sum));
            exp_l.push_back(k == nbins - 1);
        end
    endtask

    task automatic clear_queues();
        exp_d.delete(); exp_l.delete(); obs_d.delete(); obs_l.delete();
    endtask

    task automatic fill_random();
        for (int f = 0; f < NF; f++)
            for (int k = 0; k < BINS; k++) frm[f][k] = $urandom;
    endtask

    task automatic send_beat(input logic [31:0] d, input bit last, input bit gaps);
        bit rdy;
        int n;
        if (gaps && $urandom_range(0, 3) == 0) begin
            s_if.tvalid = 1'b0;
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
        end
        s_if.tdata  = d;
        s_if.tlast  = last;
        s_if.tvalid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            rdy = s_if.tready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 200);
        if (!rdy) begin
            n_vec++; n_miss++;
            $display("[TB] FAIL input_handshake got tready=0 for %0d cycles want 1", n);
        end
    endtask

    task automatic send_frame(input int f, input int nbeats, input bit gaps);
        for (int k = 0; k < nbeats; k++) send_beat(frm[f][k], k == nbeats - 1, gaps);
    endtask

    task automatic send_group(input bit gaps);
        for (int f = 0; f < NF; f++) send_frame(f, BINS, gaps);
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic wait_outputs(input int n);
        for (int i = 0; i < 600 && obs_d.size() < n; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus_reset_release();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        clear_queues();
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        s_if.tvalid = 1'b0; s_if.tlast = 1'b0; s_if.tdata = '0;
        s0_if.tvalid = 1'b0; s0_if.tlast = 1'b0; s0_if.tdata = '0;
        #2 rst_n = 1'b0;
        #2;
        n_vec++; if (m_if.tvalid !== 1'b0) begin n_miss++; $display("[TB] FAIL reset_tvalid got %b want 0", m_if.tvalid); end
        n_vec++; if (m_if.tlast !== 1'b0) begin n_miss++; $display("[TB] FAIL reset_tlast got %b want 0", m_if.tlast); end
        n_vec++; if (m_if.tdata !== 32'h0) begin n_miss++; $display("[TB] FAIL reset_tdata got %h want 0", m_if.tdata); end
        n_vec++; if (frame_err !== 1'b0) begin n_miss++; $display("[TB] FAIL reset_frame_err got %b want 0", frame_err); end
        n_vec++; if (m0_if.tvalid !== 1'b0) begin n_miss++; $display("[TB] FAIL reset_tvalid0 got %b want 0", m0_if.tvalid); end
        applyStimulus_reset_release();
        @(negedge clk);
        n_vec++; if (s_if.tready !== 1'b1) begin n_miss++; $display("[TB] FAIL reset_tready got %b want 1", s_if.tready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_steady();
        int e0 = err_cnt;
        clear_queues();
        rdy_mode = 2'd1;
        for (int f = 0; f < NF; f++)
            for (int k = 0; k < BINS; k++) frm[f][k] = 32'(4 * k + f + 1);
        push_expected(BINS);
        send_group(1'b0);
        wait_outputs(exp_d.size());
        n_vec++; if (obs_d.size() != exp_d.size()) begin n_miss++; $display("[TB] FAIL steady_count got %0d want %0d", obs_d.size(), exp_d.size()); end
        for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
            n_vec++;
            if (obs_d[i] !== exp_d[i] || obs_l[i] !== exp_l[i]) begin
                n_miss++; $display("[TB] FAIL steady_beat%0d got %h/%b want %h/%b", i, obs_d[i], obs_l[i], exp_d[i], exp_l[i]);
            end
        end
        n_vec++; if (err_cnt != e0) begin n_miss++; $display("[TB] FAIL steady_frame_err got %0d pulses want 0", err_cnt - e0); end
    endtask

    task automatic test_random();
        clear_queues();
        rdy_mode = 2'd2;
        for (int g = 0; g < 2; g++) begin
            fill_random();
            push_expected(BINS);
            send_group(1'b1);
        end
        wait_outputs(exp_d.size());
        rdy_mode = 2'd1;
        n_vec++; if (obs_d.size() != exp_d.size()) begin n_miss++; $display("[TB] FAIL random_count got %0d want %0d", obs_d.size(), exp_d.size()); end
        for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
            n_vec++;
            if (obs_d[i] !== exp_d[i] || obs_l[i] !== exp_l[i]) begin
                n_miss++; $display("[TB] FAIL random_beat%0d got %h/%b want %h/%b", i, obs_d[i], obs_l[i], exp_d[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_saturation();
        clear_queues();
        rdy_mode = 2'd1;
        for (int f = 0; f < NF; f++)
            for (int k = 0; k < BINS; k++) frm[f][k] = 32'hFFFF_FFFF;
        push_expected(BINS);
        send_group(1'b0);
        wait_outputs(exp_d.size());
        n_vec++; if (obs_d.size() != exp_d.size()) begin n_miss++; $display("[TB] FAIL sat_count got %0d want %0d", obs_d.size(), exp_d.size()); end
        for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
            n_vec++;
            if (obs_d[i] !== exp_d[i] || obs_l[i] !== exp_l[i]) begin
                n_miss++; $display("[TB] FAIL sat_beat%0d got %h/%b want %h/%b", i, obs_d[i], obs_l[i], exp_d[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d0;
        logic        l0;
        clear_queues();
        rdy_mode = 2'd1;
        fill_random();
        push_expected(BINS);
        for (int f = 0; f < NF - 1; f++) send_frame(f, BINS, 1'b0);
        rdy_mode = 2'd0;
        fork
            begin
                send_frame(NF - 1, BINS, 1'b0);
                s_if.tvalid = 1'b0;
                s_if.tlast  = 1'b0;
            end
            begin
                for (int i = 0; i < 50 && m_if.tvalid !== 1'b1; i++) @(negedge clk);
                n_vec++; if (m_if.tvalid !== 1'b1) begin n_miss++; $display("[TB] FAIL bp_first_beat got tvalid=%b want 1", m_if.tvalid); end
                d0 = m_if.tdata;
                l0 = m_if.tlast;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    n_vec++;
                    if (s_if.tready !== 1'b0 || m_if.tdata !== d0 || m_if.tlast !== l0) begin
                        n_miss++; $display("[TB] FAIL bp_hold%0d got rdy=%b %h/%b want rdy=0 %h/%b", i, s_if.tready, m_if.tdata, m_if.tlast, d0, l0);
                    end
                end
                @(posedge clk);
                #1 rdy_mode = 2'd1;
                for (int i = 0; i < BINS; i++) begin
                    @(negedge clk);
                    n_vec++; if (m_if.tvalid !== 1'b1) begin n_miss++; $display("[TB] FAIL bp_stream%0d got tvalid=%b want 1", i, m_if.tvalid); end
                end
            end
        join
        wait_outputs(exp_d.size());
        n_vec++; if (obs_d.size() != exp_d.size()) begin n_miss++; $display("[TB] FAIL bp_count got %0d want %0d", obs_d.size(), exp_d.size()); end
        for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
            n_vec++;
            if (obs_d[i] !== exp_d[i] || obs_l[i] !== exp_l[i]) begin
                n_miss++; $display("[TB] FAIL bp_beat%0d got %h/%b want %h/%b", i, obs_d[i], obs_l[i], exp_d[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_short_frame();
        int e0 = err_cnt;
        clear_queues();
        rdy_mode = 2'd1;
        fill_random();
        send_frame(0, BINS, 1'b0);
        send_frame(1, 5, 1'b0);
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++; if (err_cnt - e0 != 1) begin n_miss++; $display("[TB] FAIL short_frame_err got %0d pulses want 1", err_cnt - e0); end
        n_vec++; if (obs_d.size() != 0) begin n_miss++; $display("[TB] FAIL short_no_output got %0d beats want 0", obs_d.size()); end
        @(posedge clk);
        #1;
        fill_random();
        push_expected(BINS);
        send_group(1'b1);
        wait_outputs(exp_d.size());
        n_vec++; if (obs_d.size() != exp_d.size()) begin n_miss++; $display("[TB] FAIL short_count got %0d want %0d", obs_d.size(), exp_d.size()); end
        for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
            n_vec++;
            if (obs_d[i] !== exp_d[i] || obs_l[i] !== exp_l[i]) begin
                n_miss++; $display("[TB] FAIL short_beat%0d got %h/%b want %h/%b", i, obs_d[i], obs_l[i], exp_d[i], exp_l[i]);
            end
        end
        n_vec++; if (err_cnt - e0 != 1) begin n_miss++; $display("[TB] FAIL short_err_total got %0d want 1", err_cnt - e0); end
    endtask

    task automatic test_err_final();
        int e0 = err_cnt;
        clear_queues();
        rdy_mode = 2'd1;
        fill_random();
        push_expected(6);
        for (int f = 0; f < NF - 1; f++) send_frame(f, BINS, 1'b0);
        send_frame(NF - 1, 6, 1'b0);
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        fill_random();
        push_expected(BINS);
        send_group(1'b0);
        wait_outputs(exp_d.size());
        n_vec++; if (obs_d.size() != exp_d.size()) begin n_miss++; $display("[TB] FAIL errfinal_count got %0d want %0d", obs_d.size(), exp_d.size()); end
        for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
            n_vec++;
            if (obs_d[i] !== exp_d[i] || obs_l[i] !== exp_l[i]) begin
                n_miss++; $display("[TB] FAIL errfinal_beat%0d got %h/%b want %h/%b", i, obs_d[i], obs_l[i], exp_d[i], exp_l[i]);
            end
        end
        n_vec++; if (err_cnt - e0 != 1) begin n_miss++; $display("[TB] FAIL errfinal_frame_err got %0d pulses want 1", err_cnt - e0); end
    endtask

    task automatic test_reset_mid();
        clear_queues();
        rdy_mode = 2'd1;
        fill_random();
        for (int f = 0; f < NF - 1; f++) send_frame(f, BINS, 1'b0);
        rdy_mode = 2'd0;
        send_beat(frm[NF - 1][0], 1'b0, 1'b0);
        s_if.tdata = frm[NF - 1][1];
        @(negedge clk);
        n_vec++; if (m_if.tvalid !== 1'b1) begin n_miss++; $display("[TB] FAIL rstmid_pending got tvalid=%b want 1", m_if.tvalid); end
        n_vec++; if (s_if.tready !== 1'b0) begin n_miss++; $display("[TB] FAIL rstmid_stall got tready=%b want 0", s_if.tready); end
        #1 rst_n = 1'b0;
        #1;
        n_vec++;
        if (m_if.tvalid !== 1'b0 || m_if.tlast !== 1'b0 || m_if.tdata !== 32'h0) begin
            n_miss++; $display("[TB] FAIL rstmid_drop got %b/%b/%h want 0/0/0", m_if.tvalid, m_if.tlast, m_if.tdata);
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        rdy_mode = 2'd1;
        applyStimulus_reset_release();
        fill_random();
        push_expected(BINS);
        send_group(1'b1);
        wait_outputs(exp_d.size());
        n_vec++; if (obs_d.size() != exp_d.size()) begin n_miss++; $display("[TB] FAIL rstmid_count got %0d want %0d", obs_d.size(), exp_d.size()); end
        for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
            n_vec++;
            if (obs_d[i] !== exp_d[i] || obs_l[i] !== exp_l[i]) begin
                n_miss++; $display("[TB] FAIL rstmid_beat%0d got %h/%b want %h/%b", i, obs_d[i], obs_l[i], exp_d[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_passthrough();
        logic [31:0] d [12];
        for (int i = 0; i < 12; i++) d[i] = $urandom;
        for (int i = 0; i <= 12; i++) begin
            @(posedge clk);
            #1;
            if (i < 12) begin
                s0_if.tdata  = d[i];
                s0_if.tlast  = (i % 4 == 3);
                s0_if.tvalid = 1'b1;
            end else begin
                s0_if.tvalid = 1'b0;
                s0_if.tlast  = 1'b0;
            end
            @(negedge clk);
            n_vec++;
            if (i == 0) begin
                if (m0_if.tvalid !== 1'b0) begin n_miss++; $display("[TB] FAIL pass_idle got tvalid=%b want 0", m0_if.tvalid); end
            end else if (m0_if.tvalid !== 1'b1 || m0_if.tdata !== d[i - 1] || m0_if.tlast !== ((i - 1) % 4 == 3) || frame_err0 !== 1'b0) begin
                n_miss++; $display("[TB] FAIL pass_beat%0d got %b/%h/%b err=%b want 1/%h/%b err=0", i - 1, m0_if.tvalid, m0_if.tdata, m0_if.tlast, frame_err0, d[i - 1], ((i - 1) % 4 == 3));
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_steady();
        test_random();
        test_saturation();
        test_back_to_back();
        test_short_frame();
        test_err_final();
        test_reset_mid();
        test_passthrough();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/spectrum_averager.md
Name: spectrum_averager

Overview:
- Power-spectrum averager between the FFT magnitude-squared stage and the endian switch / packet generator.
- Accumulates 2^AVG_POW2 consecutive BINS-bin power frames per bin.
- Emits one averaged frame per 2^AVG_POW2 input frames on an AXI-stream master, framed with tlast.
- Cuts the Ethernet packet rate and reduces spectral noise variance.

Parameters:
- BINS, 256, bins per frame (power of 2, >=2)
- DATA_W, 32, input/output sample width, unsigned
- AVG_POW2, 3, log2 of frames averaged (0..8); 0 = pass-through with 1-cycle register

Ports:
- clk  in  1  clock (eth_clk domain)
- rst_n  in  1  asynchronous active-low reset
- s_axis_tdata  in  DATA_W  unsigned bin power
- s_axis_tvalid  in  1  input valid
- s_axis_tlast  in  1  last bin of input frame
- s_axis_tready  out  1  input ready
- m_axis_tdata  out  DATA_W  averaged bin power
- m_axis_tvalid  out  1  output valid
- m_axis_tlast  out  1  last bin of output frame
- m_axis_tready  in  1  output ready
- frame_err  out  1  one-cycle pulse on input framing error

Behaviour:
- Reset (async, rst_n=0):
  - bin_cnt=0, frame_cnt=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, frame_err=0.
  - Accumulator RAM is not cleared.
- Storage:
  - Accumulator RAM is BINS x ACC_W, with ACC_W = DATA_W+AVG_POW2.
  - Asynchronous read at bin_cnt; synchronous write. Maps to LUTRAM.
- Input beat accepted = s_axis_tvalid & s_axis_tready.
  - Each accepted beat increments bin_cnt, which wraps BINS-1 -> 0 and increments frame_cnt.
  - frame_cnt wraps 2^AVG_POW2-1 -> 0.
- States, decoded from frame_cnt:
  - FIRST (frame_cnt==0, not final): RAM[bin] <= zero-extended s_axis_tdata. Stale RAM content is ignored. s_axis_tready=1.
  - ACCUM (0<frame_cnt<2^AVG_POW2-1): RAM[bin] <= RAM[bin] + s_axis_tdata. No overflow is possible by width. s_axis_tready=1.
  - FINAL (frame_cnt==2^AVG_POW2-1, covers AVG_POW2=0):
    - sum = (AVG_POW2==0 ? 0 : RAM[bin]) + s_axis_tdata.
    - s_axis_tready = ~m_axis_tvalid | m_axis_tready.
    - On accept: m_axis_tdata <= sum >> AVG_POW2 (truncate), m_axis_tvalid <= 1.
    - m_axis_tlast <= (bin_cnt==BINS-1) | s_axis_tlast.
    - RAM is not written.
- Output register:
  - Latency is 1 cycle from the accepted FINAL beat.
  - m_axis_tvalid clears on m_axis_tready when no new FINAL beat is accepted the same cycle.
  - Simultaneous drain and load is allowed, giving full throughput.
  - Data/last are held stable while tvalid=1 and tready=0.
- Framing check on each accepted beat:
  - Error when s_axis_tlast=1 with bin_cnt!=BINS-1 (short frame), or s_axis_tlast=0 with bin_cnt==BINS-1 (long frame).
  - On error: frame_err=1 for 1 cycle; bin_cnt<=0, frame_cnt<=0; next beat starts a FIRST frame.
  - If the error occurs in FINAL, that beat is still emitted with m_axis_tlast=1, so downstream framing closes.
  - Long-frame case: bin_cnt wraps to 0 as normal and frame_cnt is forced to 0.
- Reset asserted mid-frame: the partial output frame is abandoned (tvalid drops immediately); restart at FIRST.

Optional Feature:
- Macro SPECTRUM_AVERAGER_ROUND_EN.
- Defined:
  - FINAL output = (sum + 2^(AVG_POW2-1)) >> AVG_POW2, round-half-up.
  - Saturates to 2^DATA_W-1 if the rounded result exceeds DATA_W.
  - For AVG_POW2=0, identical to undefined.
- Undefined: plain truncation as above; no rounding adder synthesised.

Test Plan:
- Steady averaging: BINS=8, AVG_POW2=2. Feed 4 frames where bin k = 4*k+f+1 (f = frame 0..3), tready=1. Expect exactly one output frame with bin k = 4k+2 (sum 16k+10 >> 2 truncates 2.5 -> 2), tlast only on bin 7. frame_err never pulses.
- Rounding: same stimulus. SPECTRUM_AVERAGER_ROUND_EN defined -> bin k = 4k+3. Undefined -> 4k+2. With all inputs 0xFFFFFFFF, output 0xFFFFFFFF in both builds (saturation).
- Backpressure: during FINAL, hold m_axis_tready=0 for 5 cycles. Expect s_axis_tready=0 after the first output beat, tdata/tlast stable, no beat lost or duplicated. Release -> one beat per cycle.
- Short frame: BINS=8, tlast on bin 4 of frame 1. Expect frame_err pulse. The next 4 full frames produce a correct average equal to their own values only (stale RAM ignored).
- Error in FINAL: tlast at bin 5 of frame 3. Expect output bin 5 with m_axis_tlast=1 and frame_err=1, then restart at FIRST.
- Reset mid-FINAL: drop rst_n with m_axis_tvalid=1 and tready=0. Expect tvalid=0 immediately. After release, 4 fresh frames give the correct average; AVG_POW2=0 build passes each beat with 1-cycle latency.
